// File: rtl/programmable_pipeline_delay_if.sv
// Stream and configuration bundle for the programmable pipeline delay line.
// in_*: a word moves when in_valid && in_ready on a rising edge; out_* has no backpressure.
interface programmable_pipeline_delay_if #(
  parameter int DATA_WIDTH = 512,
  parameter int MAX_DELAY  = 128
);
  localparam int DW = $clog2(MAX_DELAY) + 1;

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  cfg_load;
  logic [DW-1:0]         cfg_delay;
  logic                  cfg_busy;

  modport slave (
    input  in_valid, in_data, cfg_load, cfg_delay,
    output in_ready, out_valid, out_data, cfg_busy
  );

  modport master (
    output in_valid, in_data, cfg_load, cfg_delay,
    input  in_ready, out_valid, out_data, cfg_busy
  );
endinterface

// File: rtl/programmable_pipeline_delay.sv
// Fixed-latency delay line over a circular buffer; latency is reprogrammed by
// draining words already accepted at the old latency before switching.
module programmable_pipeline_delay #(
  parameter int DATA_WIDTH    = 512,
  parameter int MAX_DELAY     = 128,
  parameter int DEFAULT_DELAY = 100,
  parameter int CNT_WIDTH     = 32,
  localparam int DW           = $clog2(MAX_DELAY) + 1,
  localparam int PTR_W        = $clog2(MAX_DELAY)
) (
  input  logic                           clk,
  input  logic                           rst,
  programmable_pipeline_delay_if.slave   bus,
  output logic [DW-1:0]                  cur_delay,
  output logic [DW-1:0]                  inflight,
  output logic [CNT_WIDTH-1:0]           pass_cnt,
  output logic                           dbg_state
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [PTR_W-1:0]      wptr_q, wptr_d;
  logic [PTR_W-1:0]      rptr;
  logic [MAX_DELAY-1:0]  vld_q, vld_d;
  logic [DATA_WIDTH-1:0] mem_q [MAX_DELAY];
  logic [DW-1:0]         cur_delay_q, cur_delay_d;
  logic [DW-1:0]         pend_q, pend_d;
  logic [DW-1:0]         inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0]  pass_cnt_q, pass_cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  in_ready_q, in_ready_d;
  logic                  cfg_busy_q, cfg_busy_d;
  logic                  accept;
  logic                  rd_vld;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DW-1:0]         cfg_clamped;

  assign accept = bus.in_valid && in_ready_q;

  // The output register is loaded one cycle before a word is due, so the read
  // slot trails the write slot by cur_delay-1; a latency of 1 bypasses the buffer.
  assign rptr = wptr_q - PTR_W'(cur_delay_q - DW'(1));

  always_comb begin
    rd_vld  = 1'b0;
    rd_data = '0;
    if (cur_delay_q == DW'(1)) begin
      rd_vld  = accept;
      rd_data = bus.in_data;
    end else begin
      rd_vld  = vld_q[rptr];
      rd_data = mem_q[rptr];
    end
  end

  always_comb begin
    cfg_clamped = bus.cfg_delay;
    if (bus.cfg_delay == '0) begin
      cfg_clamped = DW'(1);
    end else if (bus.cfg_delay > DW'(MAX_DELAY)) begin
      cfg_clamped = DW'(MAX_DELAY);
    end
  end

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    cur_delay_d  = cur_delay_q;
    wptr_d       = wptr_q + PTR_W'(1);
    vld_d        = vld_q;
    vld_d[wptr_q] = accept;
    out_valid_d  = rd_vld;
    out_data_d   = rd_vld ? rd_data : '0;
    inflight_d   = inflight_q + DW'(accept) - DW'(rd_vld);
    pass_cnt_d   = pass_cnt_q + CNT_WIDTH'(rd_vld);

    case (state_q)
      ST_RUN: begin
        if (bus.cfg_load) begin
          state_d = ST_DRAIN;
          pend_d  = cfg_clamped;
        end
      end
      ST_DRAIN: begin
        // Stale flags behind the read slot would alias under a new latency.
        if (inflight_q == '0) begin
          state_d     = ST_RUN;
          cur_delay_d = pend_q;
          vld_d       = '0;
        end
      end
      default: state_d = ST_RUN;
    endcase

    in_ready_d = (state_d == ST_RUN);
    cfg_busy_d = (state_d == ST_DRAIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      pend_q      <= DW'(DEFAULT_DELAY);
      cur_delay_q <= DW'(DEFAULT_DELAY);
      wptr_q      <= '0;
      vld_q       <= '0;
      inflight_q  <= '0;
      pass_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b1;
      cfg_busy_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      cur_delay_q <= cur_delay_d;
      wptr_q      <= wptr_d;
      vld_q       <= vld_d;
      inflight_q  <= inflight_d;
      pass_cnt_q  <= pass_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      cfg_busy_q  <= cfg_busy_d;
    end
  end

  // Payload storage carries no reset; only the valid flags qualify it.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wptr_q] <= bus.in_data;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.cfg_busy  = cfg_busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign cur_delay     = cur_delay_q;
  assign inflight      = inflight_q;
  assign pass_cnt      = pass_cnt_q;
  assign dbg_state     = state_q;

endmodule

// File: doc/programmable_pipeline_delay.md
PROGRAMMABLE_PIPELINE_DELAY -- requirements
Module: programmable_pipeline_delay

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, meaning payload bits per word (any value >= 1).
REQ-002 SHALL have parameter MAX_DELAY, default 128, meaning maximum latency in cycles (power of two, >= 2).
REQ-003 SHALL have parameter DEFAULT_DELAY, default 100, meaning latency after reset (1..MAX_DELAY).
REQ-004 SHALL have parameter CNT_WIDTH, default 32, meaning width of pass counter.
REQ-005 SHALL have one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 in_valid  input  1  input word present.
REQ-009 in_data  input  DATA_WIDTH  input payload.
REQ-010 in_ready  output  1  word accepted when in_valid && in_ready.
REQ-011 out_valid  output  1  output word present (no backpressure; sink always accepts).
REQ-012 out_data  output  DATA_WIDTH  output payload.
REQ-013 cfg_load  input  1  one-cycle strobe requesting new latency.
REQ-014 cfg_delay  input  clog2(MAX_DELAY)+1  requested latency, sampled when cfg_load=1.
REQ-015 cfg_busy  output  1  latency change in progress.
REQ-016 cur_delay  output  clog2(MAX_DELAY)+1  latency currently applied.
REQ-017 inflight  output  clog2(MAX_DELAY)+1  valid words currently held.
REQ-018 pass_cnt  output  CNT_WIDTH  words emitted since reset.

Function
REQ-019 Storage SHALL be a MAX_DELAY-entry circular buffer with a per-entry valid flag; write pointer advances by one every cycle, wrapping from MAX_DELAY-1 to 0.
REQ-020 In state RUN, word accepted at cycle t SHALL appear on out_valid/out_data at cycle t+cur_delay exactly, in order, with no loss or duplication.
REQ-021 Cycles without acceptance SHALL write an invalid entry (bubble), emitted as out_valid=0 at the same latency.
REQ-022 out_data SHALL be all-zero whenever out_valid=0.
REQ-023 All outputs SHALL be registered.
REQ-024 States: RUN, DRAIN. in_ready=1 and cfg_busy=0 in RUN; in_ready=0 and cfg_busy=1 in DRAIN.
REQ-025 RUN -> DRAIN on cfg_load=1; the requested value SHALL be latched as pending delay after clamping: 0 -> 1, > MAX_DELAY -> MAX_DELAY.
REQ-026 In DRAIN, words already accepted SHALL continue to emerge at the old cur_delay.
REQ-027 DRAIN -> RUN when inflight reaches 0 (earliest: the cycle after the last old word is emitted); on that transition all valid flags SHALL clear and cur_delay SHALL take the pending value.
REQ-028 If inflight=0 when cfg_load arrives, DRAIN SHALL last exactly one cycle.
REQ-029 cfg_load while in DRAIN SHALL be ignored (pending value unchanged).
REQ-030 cfg_load with clamped value equal to cur_delay SHALL still pass through DRAIN.
REQ-031 inflight SHALL increment on accept, decrement on valid emit, be unchanged on simultaneous accept and emit, and never exceed cur_delay.
REQ-032 pass_cnt SHALL increment once per out_valid cycle and wrap modulo 2^CNT_WIDTH.

Reset
REQ-033 On rst=1 at a clock edge: state RUN, cur_delay=DEFAULT_DELAY, all valid flags, pointer, inflight, pass_cnt cleared, out_valid=0, out_data=0, cfg_busy=0, in_ready=1 from the next cycle.
REQ-034 Reset during DRAIN SHALL discard the pending delay and all stored words.
REQ-035 Buffer payload contents need no reset; only valid flags are cleared.

Verification
REQ-036 DEFAULT_DELAY=100, in_valid=1 with in_data=1..10 at cycles 0..9 -> out_valid=1, out_data=1..10 at cycles 100..109, pass_cnt=10, inflight peaks at 10.
REQ-037 cur_delay=4, alternating valid/idle inputs A,-,B,- -> outputs A,-,B,- starting 4 cycles later, out_data=0 on idle cycles.
REQ-038 cur_delay=8, 3 words in flight, cfg_load with cfg_delay=2 -> in_ready=0 until third word emitted; next cycle cur_delay=2, in_ready=1; following word has latency 2.
REQ-039 cfg_delay=0 -> cur_delay=1; cfg_delay=MAX_DELAY+5 -> cur_delay=MAX_DELAY; latency matches clamped value.
REQ-040 rst asserted in DRAIN with 5 words in flight -> no further out_valid, inflight=0, cur_delay=DEFAULT_DELAY, pass_cnt=0.
REQ-041 CNT_WIDTH=4, 17 words streamed -> pass_cnt=1 after wrap; continuous streaming at cur_delay=MAX_DELAY for 3*MAX_DELAY cycles -> no loss across pointer wrap.
